// File: rtl/ps2_receiver.sv
// ---------------------------------------------------------------------------
// ps2_receiver
//   Deserialises the raw PS/2 keyboard clock/data lines into one 11-bit
//   frame (start, 8 data bits LSB first, odd parity, stop). The pin clock is
//   synchronised and debounced; data is sampled on each filtered falling
//   edge. Completed frames are checked for stop bit and odd parity, and an
//   inter-bit timeout aborts stalled frames.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   reset_n    in   asynchronous active-low reset
//   ps2Clk     in   raw PS/2 clock pin (asynchronous)
//   ps2Data    in   raw PS/2 data pin (asynchronous)
//   frameOut   out  last accepted frame, first received bit in [10]
//   scanCode   out  data byte of the last accepted frame (bit 7 = frameOut[2])
//   frameValid out  one-cycle pulse when frameOut/scanCode update
//   frameError out  one-cycle pulse on start, stop, parity or timeout error
//   busy       out  high while a frame is being received
// ---------------------------------------------------------------------------
module ps2_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2Clk,
  input  logic        ps2Data,
  output logic [10:0] frameOut,
  output logic [7:0]  scanCode,
  output logic        frameValid,
  output logic        frameError,
  output logic        busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Stop bit must be 1 and data plus parity must carry an odd number of ones.
  function automatic logic frame_ok(input logic [9:0] f);
    frame_ok = f[0] & (^f[9:1]);
  endfunction

  // Data arrives LSB first, so frame bit 9 is scan bit 0 and bit 2 is scan bit 7.
  function automatic logic [7:0] scan_of(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      scan_of[i] = d[7 - i];
    end
  endfunction

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_clk_q;
  logic          filt_prev_q;
  logic [FW-1:0] filt_cnt_q;

  state_e        state_q;
  logic [10:0]   shreg_q;
  logic [3:0]    bit_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [10:0]   frame_out_q;
  logic [7:0]    scan_code_q;
  logic          frame_valid_q;
  logic          frame_error_q;
  logic          busy_q;

  logic          fall_s;
  logic          data_s;

  assign fall_s = filt_prev_q & ~filt_clk_q;
  assign data_s = data_sync_q[1];

  // Two-flop synchronisers and the PS/2 clock glitch filter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= {FW{1'b0}};
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2Clk};
      data_sync_q <= {data_sync_q[0], ps2Data};
      filt_prev_q <= filt_clk_q;
      // Only a run of FILTER_LEN disagreeing samples moves the filtered clock.
      if (clk_sync_q[1] != filt_clk_q) begin
        if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_clk_q <= clk_sync_q[1];
          filt_cnt_q <= {FW{1'b0}};
        end else begin
          filt_cnt_q <= filt_cnt_q + FW'(1);
        end
      end else begin
        filt_cnt_q <= {FW{1'b0}};
      end
    end
  end

  // Frame receive state machine with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shreg_q       <= 11'd0;
      bit_cnt_q     <= 4'd0;
      to_cnt_q      <= {TW{1'b0}};
      frame_out_q   <= 11'd0;
      scan_code_q   <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          to_cnt_q <= {TW{1'b0}};
          busy_q   <= 1'b0;
          if (fall_s) begin
            if (!data_s) begin
              shreg_q   <= 11'd0;
              bit_cnt_q <= 4'd1;
              busy_q    <= 1'b1;
              state_q   <= RECV;
            end else begin
              frame_error_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (fall_s) begin
            shreg_q   <= {shreg_q[9:0], data_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            to_cnt_q  <= {TW{1'b0}};
            if (bit_cnt_q == 4'd10) begin
              busy_q  <= 1'b0;
              state_q <= CHECK;
            end
          end else if (to_cnt_q >= TW'(TIMEOUT_CYCLES - 1)) begin
            // TIMEOUT_CYCLES cycles without a falling edge: abandon the frame.
            frame_error_q <= 1'b1;
            bit_cnt_q     <= 4'd0;
            to_cnt_q      <= {TW{1'b0}};
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        CHECK: begin
          if (frame_ok(shreg_q[9:0])) begin
            frame_out_q   <= shreg_q;
            scan_code_q   <= scan_of(shreg_q[9:2]);
            frame_valid_q <= 1'b1;
          end else begin
            frame_error_q <= 1'b1;
          end
          bit_cnt_q <= 4'd0;
          to_cnt_q  <= {TW{1'b0}};
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          bit_cnt_q <= 4'd0;
          to_cnt_q  <= {TW{1'b0}};
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign frameOut   = frame_out_q;
  assign scanCode   = scan_code_q;
  assign frameValid = frame_valid_q;
  assign frameError = frame_error_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_receiver
//   Drives PS/2 frames on the raw pins (directed cases followed by random
//   bytes, error kinds and glitches) and compares the receiver outputs with
//   a frame model built from the PS/2 framing rules.
// ---------------------------------------------------------------------------
module tb_ps2_receiver;

  localparam int FILT = 4;
  localparam int TO   = 300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ps2Clk;
  logic        ps2Data;
  logic [10:0] frameOut;
  logic [7:0]  scanCode;
  logic        frameValid;
  logic        frameError;
  logic        busy;

  ps2_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2Clk     (ps2Clk),
    .ps2Data    (ps2Data),
    .frameOut   (frameOut),
    .scanCode   (scanCode),
    .frameValid (frameValid),
    .frameError (frameError),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          hp = 20;
  int          fall_cyc = 0;
  logic        busy_mid;
  logic [10:0] exp_frame = 11'd0;
  logic [7:0]  exp_scan = 8'd0;

  // Pulse monitor state
  int          v_cnt = 0, e_cnt = 0, e_cyc = 0;
  int          v_long = 0, e_long = 0, both = 0, chg_bad = 0;
  logic        pv = 1'b0, pe = 1'b0;
  logic [10:0] pfo = 11'd0;
  logic [7:0]  psc = 8'd0;

  // Free-running cycle count used to time the inter-bit timeout.
  always @(posedge clk) cyc <= cyc + 1;

  // Count strobes, flag stretched or overlapping pulses and silent output changes.
  always @(negedge clk) begin
    if (frameValid) begin
      v_cnt <= v_cnt + 1;
      if (pv) v_long <= v_long + 1;
    end
    if (frameError) begin
      e_cnt <= e_cnt + 1;
      e_cyc <= cyc;
      if (pe) e_long <= e_long + 1;
    end
    if (frameValid && frameError) both <= both + 1;
    if (reset_n && !frameValid && (frameOut !== pfo || scanCode !== psc)) chg_bad <= chg_bad + 1;
    pv  <= frameValid;
    pe  <= frameError;
    pfo <= frameOut;
    psc <= scanCode;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clock out the first nbits of bits, MSB (bits[10]) first, optionally
  // with a 2-cycle low glitch in each clock-high phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2Data = bits[10 - i];
      if (glitch) begin
        wait_cyc(5);
        ps2Clk = 1'b0;
        wait_cyc(2);
        ps2Clk = 1'b1;
        wait_cyc(hp - 7);
      end else begin
        wait_cyc(hp);
      end
      ps2Clk   = 1'b0;
      fall_cyc = cyc;
      wait_cyc(hp);
      if (i == 4) busy_mid = busy;
      ps2Clk = 1'b1;
    end
  endtask

  // Build a frame from the byte, send it, and check the outcome.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                            input bit glitch, input string tag);
    logic [10:0] fr;
    logic        par;
    logic        stp;
    bit          ok;
    int          v0, e0;
    par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    par = par ^ flip_par;
    stp = ~bad_stop;
    fr  = 11'd0;                                  // start bit 0
    for (int i = 0; i < 8; i++) fr = fr * 2 + {10'd0, b[i]};
    fr  = fr * 2 + {10'd0, par};
    fr  = fr * 2 + {10'd0, stp};
    ok  = (stp == 1'b1) && ((($countones(b) + int'(par)) % 2) == 1);
    v0  = v_cnt;
    e0  = e_cnt;
    busy_mid = 1'bx;
    send_bits(fr, 11, glitch);
    wait_cyc(30);
    if (ok) begin
      exp_frame = fr;
      exp_scan  = b;
    end
    chk({tag, "_valid_pulses"}, v_cnt - v0, ok ? 1 : 0);
    chk({tag, "_error_pulses"}, e_cnt - e0, ok ? 0 : 1);
    chk({tag, "_frameOut"}, frameOut, exp_frame);
    chk({tag, "_scanCode"}, scanCode, exp_scan);
    chk({tag, "_busy_mid"}, busy_mid, 1'b1);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int          v0, e0;
    logic [10:0] one_bits;
    logic [10:0] part;
    bit          seen;

    reset_n = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    wait_cyc(3);
    chk("rst_frameOut", frameOut, 11'd0);
    chk("rst_scanCode", scanCode, 8'd0);
    chk("rst_frameValid", frameValid, 1'b0);
    chk("rst_frameError", frameError, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    wait_cyc(5);

    // Key 'a'
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, "key_a");
    chk("key_a_literal_frame", frameOut, 11'b000_1110_0001);

    // Parity flipped: error, outputs keep 'a'
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, "bad_parity");

    // Stop bit 0, then a good 0x24
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, "bad_stop");
    send_frame(8'h24, 1'b0, 1'b0, 1'b0, "key_24");

    // Start bit 1 in IDLE is rejected immediately
    one_bits = 11'h7FF;
    v0 = v_cnt;
    e0 = e_cnt;
    send_bits(one_bits, 1, 1'b0);
    wait_cyc(30);
    chk("bad_start_error", e_cnt - e0, 1);
    chk("bad_start_valid", v_cnt - v0, 0);
    chk("bad_start_busy", busy, 1'b0);

    // Timeout after 5 bits; error comes TO idle cycles after the filtered fall
    // (2 sync + FILT filter stages + 1 edge-detect cycle behind the pin).
    part = 11'b0_1011_0000_1;
    v0 = v_cnt;
    e0 = e_cnt;
    send_bits(part, 5, 1'b0);
    chk("timeout_busy_before", busy, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < TO + 100 && !seen; k++) begin
      wait_cyc(1);
      if (e_cnt != e0) seen = 1'b1;
    end
    chk("timeout_seen", seen, 1'b1);
    chk("timeout_latency", e_cyc - fall_cyc, TO + 7);
    wait_cyc(10);
    chk("timeout_error_pulses", e_cnt - e0, 1);
    chk("timeout_valid_pulses", v_cnt - v0, 0);
    chk("timeout_busy_after", busy, 1'b0);
    chk("timeout_frameOut_kept", frameOut, exp_frame);
    send_frame(8'h3B, 1'b0, 1'b0, 1'b0, "after_timeout");

    // Glitches on the clock between bits
    send_frame(8'hA7, 1'b0, 1'b0, 1'b1, "glitch");

    // Reset mid-frame after bit 6
    part = 11'b0_1100_1010_0;
    v0 = v_cnt;
    e0 = e_cnt;
    send_bits(part, 6, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_frameOut", frameOut, 11'd0);
    chk("midrst_scanCode", scanCode, 8'd0);
    chk("midrst_frameValid", frameValid, 1'b0);
    chk("midrst_frameError", frameError, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(30);
    chk("midrst_no_valid", v_cnt - v0, 0);
    chk("midrst_no_error", e_cnt - e0, 0);
    exp_frame = 11'd0;
    exp_scan  = 8'd0;
    send_frame(8'h4D, 1'b0, 1'b0, 1'b0, "after_reset");

    // Random frames
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      int         kind;
      b    = 8'($urandom);
      kind = $urandom_range(0, 3);
      hp   = $urandom_range(15, 30);
      send_frame(b, kind == 2, kind == 3, $urandom_range(0, 1) == 1, "random");
    end

    chk("stretched_valid", v_long, 0);
    chk("stretched_error", e_long, 0);
    chk("valid_and_error_together", both, 0);
    chk("output_change_without_valid", chg_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
